// File: rtl/retire_pkg.sv
// Shared types for the retirement-stream checker.
//   ret_kind_t   : kind of a retired architectural effect
//   ret_rec_t    : one retired/golden record {kind, pc, addr, data}
//   ERR_*        : bit positions inside the err_field output
//   chk_state_t  : checker FSM states
//   rec_diff()   : per-field comparison of a retired record against a golden one
package retire_pkg;

   typedef enum logic [1:0] {
      REG  = 2'd0,
      MEM  = 2'd1,
      PC   = 2'd2,
      RSVD = 2'd3
   } ret_kind_t;

   typedef struct packed {
      ret_kind_t   kind;
      logic [15:0] pc;
      logic [15:0] addr;
      logic [15:0] data;
   } ret_rec_t;

   localparam int REC_W = $bits(ret_rec_t);

   localparam int ERR_KIND = 0;
   localparam int ERR_PC   = 1;
   localparam int ERR_ADDR = 2;
   localparam int ERR_DATA = 3;
   localparam int ERR_OVF  = 4;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_ERROR = 2'd1,
      ST_DONE  = 2'd2
   } chk_state_t;

   // Returns one bit per failing field. The address rule follows the
   // retired kind: reg writes only carry a 4-bit index, redirects carry none.
   function automatic logic [3:0] rec_diff(input ret_rec_t act, input ret_rec_t gold);
      logic [3:0] d;
      d = '0;
      d[ERR_KIND] = (act.kind != gold.kind) || (act.kind == RSVD) || (gold.kind == RSVD);
      d[ERR_PC]   = (act.pc != gold.pc);
      case (act.kind)
         REG:     d[ERR_ADDR] = (act.addr[3:0] != gold.addr[3:0]);
         MEM:     d[ERR_ADDR] = (act.addr != gold.addr);
         default: d[ERR_ADDR] = 1'b0;
      endcase
      d[ERR_DATA] = (act.data != gold.data);
      return d;
   endfunction

endpackage

// File: rtl/retire_fifo.sv
// Capture buffer: DEPTH-entry synchronous FIFO of packed retirement records.
// Ports:
//   i_clk, i_rst_n      clock, asynchronous active-low reset (empties buffer)
//   i_push, i_wdata     write one record (caller guarantees !full or same-cycle pop)
//   i_pop               drop head record (caller guarantees !empty)
//   o_rdata             head record, valid while !o_empty
//   o_full, o_empty     occupancy flags
// DEPTH must be a power of 2 so the pointers wrap naturally.
module retire_fifo
   import retire_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_push,
   input  logic [REC_W-1:0] i_wdata,
   input  logic             i_pop,
   output logic [REC_W-1:0] o_rdata,
   output logic             o_full,
   output logic             o_empty
);

   localparam int AW = $clog2(DEPTH);

   logic [REC_W-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;

   // Storage carries no reset; occupancy alone decides what is valid.
   always_ff @(posedge i_clk) begin
      if (i_push) r_mem[r_wr_ptr] <= i_wdata;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (i_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         if (i_push && !i_pop)      r_count <= r_count + (AW+1)'(1);
         else if (i_pop && !i_push) r_count <= r_count - (AW+1)'(1);
      end
   end

   assign o_rdata = r_mem[r_rd_ptr];
   assign o_full  = (r_count == (AW+1)'(DEPTH));
   assign o_empty = (r_count == '0);

endmodule

// File: rtl/retire_checker.sv
// Retirement-stream checker: captures retired effects into a small buffer and
// compares them in order against golden records from a reference model.
// Ports:
//   i_clk, i_rst_n                 clock, asynchronous active-low reset
//   i_ret_valid/kind/pc/addr/data  retired effect tap
//   i_halt                         CPU halted (level)
//   i_exp_valid/kind/pc/addr/data  golden record; o_exp_ready consumes it
//   o_mismatch                     sticky first-divergence flag
//   o_err_pc, o_err_field          PC and cause bits of the first failure
//   o_match_count                  passing compares, saturating
//   o_err_count                    (RETIRE_CHECK_CONTINUE_EN only) failures, saturating
//   o_done, o_pass                 FSM in DONE; DONE without mismatch
//   o_dbg_state                    current FSM state
// Handshake: a golden record transfers in any cycle where i_exp_valid and
// o_exp_ready are both 1; o_exp_ready depends only on state, buffer occupancy
// and i_exp_valid, never on golden data.
// Build option: RETIRE_CHECK_CONTINUE_EN keeps checking after a mismatch and
// adds o_err_count.
module retire_checker
   import retire_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int CNT_W = 16
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_ret_valid,
   input  logic [1:0]       i_ret_kind,
   input  logic [15:0]      i_ret_pc,
   input  logic [15:0]      i_ret_addr,
   input  logic [15:0]      i_ret_data,
   input  logic             i_halt,
   input  logic             i_exp_valid,
   output logic             o_exp_ready,
   input  logic [1:0]       i_exp_kind,
   input  logic [15:0]      i_exp_pc,
   input  logic [15:0]      i_exp_addr,
   input  logic [15:0]      i_exp_data,
   output logic             o_mismatch,
   output logic [15:0]      o_err_pc,
   output logic [4:0]       o_err_field,
   output logic [CNT_W-1:0] o_match_count,
`ifdef RETIRE_CHECK_CONTINUE_EN
   output logic [CNT_W-1:0] o_err_count,
`endif
   output logic             o_done,
   output logic             o_pass,
   output logic [1:0]       o_dbg_state
);

`ifdef RETIRE_CHECK_CONTINUE_EN
   localparam bit CONTINUE_EN = 1'b1;
`else
   localparam bit CONTINUE_EN = 1'b0;
`endif

   chk_state_t       r_state;
   chk_state_t       w_next;
   logic             r_mismatch;
   logic [15:0]      r_err_pc;
   logic [4:0]       r_err_field;
   logic [CNT_W-1:0] r_match_count;

   ret_rec_t         w_ret_rec;
   ret_rec_t         w_exp_rec;
   ret_rec_t         w_head_rec;
   logic [REC_W-1:0] w_head_raw;
   logic             w_full;
   logic             w_empty;
   logic             w_run;
   logic             w_fire;
   logic [3:0]       w_diff;
   logic             w_cmp_fail;
   logic             w_ovf;
   logic             w_extra;
   logic             w_fail;
   logic             w_push;
   logic [15:0]      w_fail_pc;
   logic [4:0]       w_fail_field;

   assign w_ret_rec = '{kind: ret_kind_t'(i_ret_kind), pc: i_ret_pc, addr: i_ret_addr, data: i_ret_data};
   assign w_exp_rec = '{kind: ret_kind_t'(i_exp_kind), pc: i_exp_pc, addr: i_exp_addr, data: i_exp_data};
   assign w_head_rec = ret_rec_t'(w_head_raw);

   assign w_run      = (r_state == ST_RUN);
   assign w_fire     = w_run && !w_empty && i_exp_valid;
   assign w_diff     = rec_diff(w_head_rec, w_exp_rec);
   assign w_cmp_fail = w_fire && (w_diff != 4'b0000);
   // A pop in the same cycle frees the slot, so only an un-popped full push drops.
   assign w_ovf      = w_run && i_ret_valid && w_full && !w_fire;
   assign w_extra    = (r_state == ST_DONE) && i_ret_valid;
   assign w_fail     = w_cmp_fail || w_ovf || w_extra;
   assign w_push     = w_run && i_ret_valid && (!w_full || w_fire);

   // Compare failure and overflow are mutually exclusive (overflow needs no pop).
   assign w_fail_pc    = w_cmp_fail ? w_head_rec.pc : i_ret_pc;
   assign w_fail_field = w_cmp_fail ? {1'b0, w_diff} : 5'(1 << ERR_OVF);

   retire_fifo #(.DEPTH(DEPTH)) u_fifo (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_push  (w_push),
      .i_wdata (w_ret_rec),
      .i_pop   (w_fire),
      .o_rdata (w_head_raw),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= ST_RUN;
      else          r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_RUN: begin
            if (w_fail && !CONTINUE_EN)               w_next = ST_ERROR;
            else if (i_halt && w_empty && !w_fire)    w_next = ST_DONE;
         end
         ST_ERROR: w_next = ST_ERROR;
         ST_DONE:  w_next = ST_DONE;
         default:  w_next = ST_RUN;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_mismatch    <= 1'b0;
         r_err_pc      <= '0;
         r_err_field   <= '0;
         r_match_count <= '0;
      end else begin
         if (w_fail) begin
            r_mismatch <= 1'b1;
            if (!r_mismatch) begin
               r_err_pc    <= w_fail_pc;
               r_err_field <= w_fail_field;
            end
         end
         if (w_fire && !w_cmp_fail && (r_match_count != '1))
            r_match_count <= r_match_count + CNT_W'(1);
      end
   end

`ifdef RETIRE_CHECK_CONTINUE_EN
   logic [CNT_W-1:0] r_err_count;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)                          r_err_count <= '0;
      else if (w_fail && (r_err_count != '1)) r_err_count <= r_err_count + CNT_W'(1);
   end

   assign o_err_count = r_err_count;
`endif

   assign o_exp_ready   = w_fire;
   assign o_mismatch    = r_mismatch;
   assign o_err_pc      = r_err_pc;
   assign o_err_field   = r_err_field;
   assign o_match_count = r_match_count;
   assign o_done        = (r_state == ST_DONE);
   assign o_pass        = (r_state == ST_DONE) && !r_mismatch;
   assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_retire_checker.sv
module tb_retire_checker;

  localparam int DEPTH = 4;
  localparam int CNT_W = 16;
`ifdef RETIRE_CHECK_CONTINUE_EN
  localparam bit CONT = 1'b1;
`else
  localparam bit CONT = 1'b0;
`endif

  // ---------------- clock / reset / signals ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic ret_valid = 1'b0;
  logic [1:0] ret_kind = '0;
  logic [15:0] ret_pc = '0, ret_addr = '0, ret_data = '0;
  logic halt = 1'b0;
  logic exp_valid = 1'b0;
  logic [1:0] exp_kind = '0;
  logic [15:0] exp_pc = '0, exp_addr = '0, exp_data = '0;
  logic exp_ready, mismatch, done, pass;
  logic [15:0] err_pc;
  logic [4:0] err_field;
  logic [CNT_W-1:0] match_count;
  logic [1:0] dbg_state;
`ifdef RETIRE_CHECK_CONTINUE_EN
  logic [CNT_W-1:0] err_count;
`endif

  always #5 clk = ~clk;

  retire_checker #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_ret_valid(ret_valid), .i_ret_kind(ret_kind), .i_ret_pc(ret_pc),
    .i_ret_addr(ret_addr), .i_ret_data(ret_data), .i_halt(halt),
    .i_exp_valid(exp_valid), .o_exp_ready(exp_ready), .i_exp_kind(exp_kind),
    .i_exp_pc(exp_pc), .i_exp_addr(exp_addr), .i_exp_data(exp_data),
    .o_mismatch(mismatch), .o_err_pc(err_pc), .o_err_field(err_field),
    .o_match_count(match_count),
`ifdef RETIRE_CHECK_CONTINUE_EN
    .o_err_count(err_count),
`endif
    .o_done(done), .o_pass(pass), .o_dbg_state(dbg_state)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [1:0]  k;
    logic [15:0] pc;
    logic [15:0] a;
    logic [15:0] d;
  } trec_t;

  localparam int M_RUN = 0, M_ERR = 1, M_DONE = 2;

  trec_t m_q[$];
  int m_st = M_RUN;
  bit m_mis = 0;
  logic [15:0] m_epc = '0;
  logic [4:0] m_ef = '0;
  int m_match = 0;
  int m_ecnt = 0;

  function automatic logic [4:0] spec_diff(input trec_t r, input trec_t g);
    logic [4:0] f;
    f = '0;
    if (r.k != g.k || r.k == 2'd3 || g.k == 2'd3) f[0] = 1'b1;
    if (r.pc != g.pc) f[1] = 1'b1;
    if (r.k == 2'd0 && r.a[3:0] != g.a[3:0]) f[2] = 1'b1;
    if (r.k == 2'd1 && r.a != g.a) f[2] = 1'b1;
    if (r.d != g.d) f[3] = 1'b1;
    return f;
  endfunction

  task automatic m_fail(input logic [15:0] pc, input logic [4:0] f);
    if (!m_mis) begin
      m_epc = pc;
      m_ef = f;
    end
    m_mis = 1;
    if (m_ecnt < (1 << CNT_W) - 1) m_ecnt++;
  endtask

  task automatic m_reset();
    m_q.delete();
    m_st = M_RUN; m_mis = 0; m_epc = '0; m_ef = '0; m_match = 0; m_ecnt = 0;
  endtask

  task automatic model_step();
    bit was_empty, fire, failed;
    trec_t h, g, r;
    logic [4:0] df;
    failed = 0;
    was_empty = (m_q.size() == 0);
    fire = (m_st == M_RUN) && !was_empty && exp_valid;
    if (fire) begin
      h = m_q.pop_front();
      g = '{k: exp_kind, pc: exp_pc, a: exp_addr, d: exp_data};
      df = spec_diff(h, g);
      if (df != 0) begin
        m_fail(h.pc, df);
        failed = 1;
      end else if (m_match < (1 << CNT_W) - 1) begin
        m_match++;
      end
    end
    if (ret_valid) begin
      r = '{k: ret_kind, pc: ret_pc, a: ret_addr, d: ret_data};
      if (m_st == M_RUN) begin
        if (m_q.size() < DEPTH) m_q.push_back(r);
        else begin
          m_fail(ret_pc, 5'b10000);
          failed = 1;
        end
      end else if (m_st == M_DONE) begin
        m_fail(ret_pc, 5'b10000);
      end
    end
    if (m_st == M_RUN) begin
      if (failed && !CONT) m_st = M_ERR;
      else if (halt && was_empty && !fire) m_st = M_DONE;
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) m_reset();
      else model_step();
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      chk("exp_ready", exp_ready, (m_st == M_RUN) && (m_q.size() > 0) && exp_valid);
      chk("mismatch", mismatch, m_mis);
      chk("err_pc", err_pc, m_epc);
      chk("err_field", err_field, m_ef);
      chk("match_count", match_count, m_match);
      chk("done", done, m_st == M_DONE);
      chk("pass", pass, (m_st == M_DONE) && !m_mis);
`ifdef RETIRE_CHECK_CONTINUE_EN
      chk("err_count", err_count, m_ecnt);
`endif
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ret(input logic [1:0] k, input logic [15:0] pc, input logic [15:0] a, input logic [15:0] d);
    ret_valid = 1; ret_kind = k; ret_pc = pc; ret_addr = a; ret_data = d;
    tick();
    ret_valid = 0;
  endtask

  task automatic send_exp(input logic [1:0] k, input logic [15:0] pc, input logic [15:0] a, input logic [15:0] d);
    int w;
    exp_valid = 1; exp_kind = k; exp_pc = pc; exp_addr = a; exp_data = d;
    w = 0;
    while (1) begin
      @(negedge clk);
      if (exp_ready) break;
      w++;
      if (w > 20) begin
        chk("exp_wait_timeout", 0, 1);
        break;
      end
    end
    tick();
    exp_valid = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    ret_valid = 0; exp_valid = 0; halt = 0;
    tick(); tick();
    rst_n = 1;
    tick();
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    #1 rst_n = 0;
    tick(); tick();
    rst_n = 1;
    tick();
    chk("rst_mismatch", mismatch, 0);
    chk("rst_match", match_count, 0);
    chk("rst_done", done, 0);
    chk("rst_exp_ready", exp_ready, 0);

    // Three matching records then halt.
    ret(2'd0, 16'h0000, 16'h0001, 16'h1234);
    ret(2'd1, 16'h0002, 16'h0040, 16'hBEEF);
    ret(2'd2, 16'h0004, 16'h0000, 16'h0010);
    send_exp(2'd0, 16'h0000, 16'h0001, 16'h1234);
    send_exp(2'd1, 16'h0002, 16'h0040, 16'hBEEF);
    send_exp(2'd2, 16'h0004, 16'h0000, 16'h0010);
    halt = 1;
    tick(); tick();
    chk("t1_match", match_count, 3);
    chk("t1_done", done, 1);
    chk("t1_pass", pass, 1);
    do_reset();

    // Data mismatch; checker then refuses golden records.
    ret(2'd0, 16'h0006, 16'h0002, 16'h1234);
    send_exp(2'd0, 16'h0006, 16'h0002, 16'h1235);
    chk("t2_mismatch", mismatch, 1);
    chk("t2_err_pc", err_pc, 16'h0006);
    chk("t2_err_field", err_field, 5'b01000);
    exp_valid = 1; exp_kind = 0; exp_pc = 16'h0008;
    ret_valid = 1; ret_kind = 0; ret_pc = 16'h0008;
    repeat (3) begin
      @(negedge clk);
      chk("t2_ready_after_err", exp_ready, 0);
    end
    tick();
    ret_valid = 0; exp_valid = 0;
    do_reset();
    chk("rst2_err_pc", err_pc, 0);
    chk("rst2_err_field", err_field, 0);
    chk("rst2_mismatch", mismatch, 0);

    // Address rules per kind.
    ret(2'd2, 16'h0008, 16'h1111, 16'h0010);
    send_exp(2'd2, 16'h0008, 16'h2222, 16'h0010);
    ret(2'd0, 16'h000A, 16'h0103, 16'h0055);
    send_exp(2'd0, 16'h000A, 16'h0003, 16'h0055);
    ret(2'd1, 16'h000C, 16'h0140, 16'h0077);
    send_exp(2'd1, 16'h000C, 16'h0040, 16'h0077);
    chk("t3_match", match_count, 2);
    chk("t3_err_field", err_field, 5'b00100);
    chk("t3_err_pc", err_pc, 16'h000C);
    do_reset();

    // Overflow: DEPTH+1 retirements with no golden records.
    for (int i = 0; i <= DEPTH; i++) ret(2'd0, 16'(i * 2), 16'(i), 16'(i + 7));
    chk("t4_err_field", err_field, 5'b10000);
    chk("t4_mismatch", mismatch, 1);
    chk("t4_err_pc", err_pc, 16'(DEPTH * 2));
    do_reset();

    // Full buffer with push and pop in one cycle.
    for (int i = 0; i < DEPTH; i++) ret(2'd0, 16'(16'h0010 + i), 16'(i), 16'(16'h0100 + i));
    ret_valid = 1; ret_kind = 0; ret_pc = 16'h0030; ret_addr = 16'h0005; ret_data = 16'h0200;
    exp_valid = 1; exp_kind = 0; exp_pc = 16'h0010; exp_addr = 16'h0000; exp_data = 16'h0100;
    @(negedge clk);
    chk("t4b_ready_full", exp_ready, 1);
    tick();
    ret_valid = 0; exp_valid = 0;
    chk("t4b_no_ovf", mismatch, 0);
    chk("t4b_match1", match_count, 1);
    for (int i = 1; i < DEPTH; i++) send_exp(2'd0, 16'(16'h0010 + i), 16'(i), 16'(16'h0100 + i));
    send_exp(2'd0, 16'h0030, 16'h0005, 16'h0200);
    halt = 1;
    tick(); tick();
    chk("t4b_match_all", match_count, DEPTH + 1);
    chk("t4b_pass", pass, 1);
    do_reset();

    // Retirement after DONE.
    halt = 1;
    tick(); tick();
    chk("t5_done", done, 1);
    ret(2'd0, 16'h0020, 16'h0003, 16'h0009);
    chk("t5_err_field", err_field, 5'b10000);
    chk("t5_err_pc", err_pc, 16'h0020);
    chk("t5_pass", pass, 0);
    chk("t5_still_done", done, 1);
    do_reset();

    // Asynchronous reset mid-stream discards buffered entries.
    ret(2'd0, 16'h0050, 16'h0001, 16'h0011);
    ret(2'd0, 16'h0052, 16'h0002, 16'h0022);
    send_exp(2'd0, 16'h0050, 16'h0001, 16'h0011);
    ret(2'd0, 16'h0054, 16'h0003, 16'h0033);
    chk("t6_pre_match", match_count, 1);
    @(posedge clk);
    #3 rst_n = 0;
    #1;
    chk("t6_async_match", match_count, 0);
    chk("t6_async_mismatch", mismatch, 0);
    chk("t6_async_done", done, 0);
    chk("t6_async_ready", exp_ready, 0);
    tick();
    rst_n = 1;
    tick();
    exp_valid = 1; exp_kind = 0; exp_pc = 16'h0052; exp_addr = 16'h0002; exp_data = 16'h0022;
    @(negedge clk);
    chk("t6_buffer_empty", exp_ready, 0);
    tick();
    exp_valid = 0;
    halt = 1;
    tick(); tick();
    chk("t6_done_empty", done, 1);
    chk("t6_match_zero", match_count, 0);
    do_reset();

`ifdef RETIRE_CHECK_CONTINUE_EN
    // Continue mode: two bad compares among five.
    ret(2'd0, 16'h0040, 16'h0001, 16'h0001);
    ret(2'd0, 16'h0042, 16'h0002, 16'h0002);
    ret(2'd0, 16'h0044, 16'h0003, 16'h0003);
    ret(2'd0, 16'h0046, 16'h0004, 16'h0004);
    send_exp(2'd0, 16'h0040, 16'h0001, 16'h0001);
    send_exp(2'd0, 16'h0042, 16'h0002, 16'h00FF);
    send_exp(2'd0, 16'h0044, 16'h0003, 16'h0003);
    ret(2'd0, 16'h0048, 16'h0005, 16'h0005);
    send_exp(2'd0, 16'h0047, 16'h0004, 16'h0004);
    send_exp(2'd0, 16'h0048, 16'h0005, 16'h0005);
    halt = 1;
    tick(); tick();
    chk("tc_err_count", err_count, 2);
    chk("tc_match", match_count, 3);
    chk("tc_done", done, 1);
    chk("tc_pass", pass, 0);
    chk("tc_err_pc", err_pc, 16'h0042);
    chk("tc_err_field", err_field, 5'b01000);
    do_reset();
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/retire_checker.md
# retire_checker

Synthesizable retirement-stream checker for the 16-bit CPU. It captures every retired architectural effect (register write, memory store, taken-branch redirect) into a small buffer and compares each one, in order, against golden records streamed in over a valid/ready port from a reference-model source. It sits beside `main`, tapping the retire port, and reports the first divergence with PC and field, plus a match count and a final pass flag at halt.

## Interface
- `DEPTH`, default 4: capture buffer entries; power of 2, minimum 2.
- `CNT_W`, default 16: width of the match counter (and error counter when enabled).
- `clk`  in  1  clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `ret_valid`  in  1  one retired effect this cycle.
- `ret_kind`  in  2  0 = reg write, 1 = mem store, 2 = pc redirect, 3 = reserved.
- `ret_pc`  in  16  PC of the retiring instruction.
- `ret_addr`  in  16  register index (bits [3:0]) or memory address; don't-care for redirect.
- `ret_data`  in  16  written value, stored value, or jump target.
- `halt`  in  1  CPU halted; level, sampled every cycle.
- `exp_valid`  in  1  golden record available.
- `exp_ready`  out  1  golden record consumed this cycle.
- `exp_kind` / `exp_pc` / `exp_addr` / `exp_data`  in  2/16/16/16  golden record, same encoding as `ret_*`.
- `mismatch`  out  1  sticky: first divergence captured.
- `err_pc`  out  16  `ret_pc` of the first failing entry.
- `err_field`  out  5  first failure cause: [0] kind, [1] pc, [2] addr, [3] data, [4] overflow/extra retirement.
- `match_count`  out  CNT_W  compares that passed; saturates at all-ones.
- `done`  out  1  FSM in DONE.
- `pass`  out  1  `done && !mismatch`.

## Operation
- Capture buffer: `ret_valid` pushes {kind, pc, addr, data}. Push while full with no same-cycle pop drops the entry and flags `err_field[4]`.
- Compare fires when state is RUN, buffer non-empty, and `exp_valid` = 1. `exp_ready` equals that condition combinationally, and the buffer head pops in the same cycle.
- Field rules: kind always compared, and kind 3 on either side is a kind mismatch. PC always compared. Addr is compared on bits [3:0] for reg writes, on all 16 bits for stores, and not at all for redirects. Data always compared.
- FSM states:
  - RUN → ERROR on the first failing compare or on an overflow.
  - RUN → DONE when `halt` = 1, the buffer is empty, and no compare fires that cycle.
  - ERROR holds until reset: `exp_ready` = 0, pushes ignored.
  - DONE holds until reset. A `ret_valid` in DONE is an extra retirement: sets `mismatch`, `err_field` = 5'b10000, `err_pc` = `ret_pc`, and stays in DONE.
- First-error capture: `err_pc`/`err_field` load only while `mismatch` = 0. Several fields failing together set several bits.
- Simultaneous push and pop are legal at any occupancy, including full. A push to an empty buffer cannot be compared in the same cycle.

## Timing
- Reset values: buffer empty, state RUN, `exp_ready` = 0, `mismatch` = 0, `err_pc` = 0, `err_field` = 0, `match_count` = 0, `done` = 0, `pass` = 0.
- A retirement at edge N is comparable in cycle N+1 at the earliest.
- `mismatch`, `err_*`, `match_count`, and the state are registered. They reflect a compare in cycle C after edge C+1.
- `exp_ready` is combinational from state, buffer occupancy, and `exp_valid`. No combinational path from `exp_*` data to any output.
- Reset mid-stream: immediate clear, and buffered entries are discarded.

## Configuration
- `RETIRE_CHECK_CONTINUE_EN` undefined: first mismatch enters ERROR and checking stops, as above.
- `RETIRE_CHECK_CONTINUE_EN` defined:
  - Mismatches do not leave RUN, so compares continue and DONE is still reachable.
  - An extra port `err_count` (out, CNT_W, saturating, reset 0) counts every failing compare, overflow, and extra retirement.
  - `err_pc`/`err_field` still hold the first failure only.

## Structure
- Package `retire_pkg`:
  - `ret_kind_t` enum (REG, MEM, PC, RSVD).
  - `ret_rec_t` packed struct {kind, pc, addr, data}.
  - `ERR_KIND`/`ERR_PC`/`ERR_ADDR`/`ERR_DATA`/`ERR_OVF` bit-index constants.
  - FSM state enum.
- One sub-module, `retire_fifo`: parameterized DEPTH × `ret_rec_t` synchronous FIFO with full/empty and simultaneous push/pop.

## Test plan
- Three matching records {REG, pc 0x0000, r1, 0x1234}, {MEM, 0x0002, 0x0040, 0xBEEF}, {PC, 0x0004, –, 0x0010}, then `halt`: expect `match_count` = 3, `done` = 1, `pass` = 1.
- Golden data 0x1235 against retired 0x1234 at pc 0x0006: expect `mismatch` = 1, `err_pc` = 0x0006, `err_field` = 5'b01000, and `exp_ready` stays 0 afterwards.
- Redirect records with different `ret_addr` but equal target: expect a match. A reg write differing only in addr bit 8: expect a match. A store differing in addr bit 8: expect `err_field[2]` set.
- With `exp_valid` held 0, retire DEPTH+1 entries: expect `err_field` = 5'b10000 and `mismatch` = 1. Full buffer with push and pop in the same cycle: no overflow.
- Retirement after DONE at pc 0x0020: expect `err_field` = 5'b10000, `pass` = 0. Assert `rst_n` mid-stream: all outputs return to reset values asynchronously.
- With `RETIRE_CHECK_CONTINUE_EN`: two bad compares among five, then `halt`: expect `err_count` = 2, `match_count` = 3, `done` = 1, `pass` = 0.
